pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Next-generation hazard and flow controller for the 5-stage RV32I pipeline. It generates PC enable, stage enables and flushes from I/D-memory handshakes, EX-stage control-flow resolution and ID/EX operand dependencies. Compared with the previous generation it adds:
- a registered pending-redirect (target held until I-mem responds);
- static or external-predictor modes;
- configurable load-use bubble depth, with x0 and unused-operand filtering;
- saturating performance counters.
It sits beside the datapath between fetch control and the pipeline registers.

Parameters:
XLEN, 32, width of PC/target values
CNT_WIDTH, 32, width of each performance counter
LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..4)
PRED_MODE, 0, 0 = static not-taken; 1 = external predictor supplies pred_taken_ex

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
imem_resp  in  1  I-mem response this cycle
dmem_resp  in  1  D-mem response this cycle
dmem_read_mem  in  1  MEM-stage load request
dmem_write_mem  in  1  MEM-stage store request
rs1_id  in  5  ID source reg 1
rs2_id  in  5  ID source reg 2
rs1_used_id  in  1  ID instruction reads rs1
rs2_used_id  in  1  ID instruction reads rs2
opcode_ex  in  7  EX opcode (rv32i_opcode)
rd_ex  in  5  EX destination reg
br_en  in  1  EX branch condition true
pred_taken_ex  in  1  fetch predicted taken (ignored when PRED_MODE=0)
alu_out_ex  in  XLEN  EX computed target
pc_plus4_ex  in  XLEN  EX PC+4
pc_en  out  1  PC register load enable
redirect_valid  out  1  PC must load redirect_pc
redirect_pc  out  XLEN  corrected fetch target
IFID_en, IDEX_en, EXMEM_en, MEMWB_en  out  1 each  pipeline register enables
IFID_flush, IDEX_flush  out  1 each  insert bubble on enable
mispredict  out  1  EX-stage control-flow mispredict this cycle
perf_clr  in  1  synchronous clear of all counters
mispredict_cnt, stall_cnt, lu_bubble_cnt  out  CNT_WIDTH each  saturating counters

Behaviour:
- Derived signals:
  - dreq = dmem_read_mem | dmem_write_mem
  - mem_ok = dmem_resp | ~dreq
  - full_adv = imem_resp & mem_ok
  - back_adv = full_adv | (~imem_resp & dmem_resp)
- Base enables: EXMEM_en = MEMWB_en = IDEX_en = IFID_en = back_adv. IFID_flush = ~imem_resp & back_adv.
- Mispredict condition:
  - PRED_MODE=0: (op_br & br_en) | op_jal | op_jalr.
  - PRED_MODE=1: (op_br & (br_en != pred_taken_ex)) | op_jalr | (op_jal & ~pred_taken_ex).
  - mispredict output is asserted only when the FSM is in RUN.
- Target selection, in priority order:
  - op_jalr → alu_out_ex with bit 0 cleared.
  - op_jal, or op_br taken → alu_out_ex.
  - op_br not taken → pc_plus4_ex.
- Load-use condition: opcode_ex = op_load, rd_ex ≠ 0, and ((rs1_used_id & rd_ex = rs1_id) | (rs2_used_id & rd_ex = rs2_id)).
- FSM states: RUN, LU_STALL, REDIR_WAIT. Reset state is RUN.
- RUN, mispredict & full_adv:
  - redirect_valid = 1, redirect_pc = target, pc_en = 1.
  - IFID_flush = IDEX_flush = 1.
  - Stay in RUN.
- RUN, mispredict & back_adv & ~imem_resp:
  - Latch target into the redirect register; go to REDIR_WAIT.
  - IFID_flush = IDEX_flush = 1; pc_en = 0.
- RUN, load-use & back_adv (and no mispredict):
  - IFID_en = 0, IDEX_flush = 1, pc_en = 0.
  - If LU_STALL_CYCLES > 1: load down-counter with LU_STALL_CYCLES−1 and go to LU_STALL.
- RUN, otherwise: pc_en = full_adv.
- LU_STALL:
  - Each back_adv cycle: IFID_en = 0, IDEX_flush = 1, pc_en = 0, decrement the counter.
  - Return to RUN on the cycle the counter reaches 0.
  - Cycles without back_adv hold the counter.
- REDIR_WAIT:
  - redirect_valid = 1, redirect_pc = latched value, IFID_flush = 1 on every IFID-enabled cycle.
  - On imem_resp: pc_en = 1, return to RUN.
  - dmem stalls behave as the base enables.
- Reset values: FSM = RUN, redirect register = 0, LU counter = 0, all counters = 0. With all inputs low, every output is 0.
- Counters:
  - mispredict_cnt +1 per cycle where mispredict & back_adv.
  - stall_cnt +1 per cycle where pc_en = 0.
  - lu_bubble_cnt +1 per inserted load-use bubble.
  - All three saturate at all-ones.
  - perf_clr has priority over increment.
  - Reset mid-operation (including in REDIR_WAIT) aborts immediately; no redirect survives reset.

Test Plan:
1. PRED_MODE=0, beq taken, alu_out_ex=0x100, imem_resp=1, no dreq → same cycle: redirect_valid=1, redirect_pc=0x100, pc_en=1, IFID_flush=IDEX_flush=1, mispredict_cnt=1 next cycle.
2. jalr, alu_out_ex=0x203, imem_resp=0 for 3 cycles then 1 → REDIR_WAIT for 3 cycles with redirect_pc=0x202 and pc_en=0; pc_en=1 on the 4th cycle; FSM back in RUN.
3. LU_STALL_CYCLES=3: load rd_ex=5, ID rs2_id=5 with rs2_used_id=1 → 3 consecutive bubbles (IFID_en=0, IDEX_flush=1), lu_bubble_cnt=3; same with rd_ex=0 → no stall.
4. dreq=1, dmem_resp=0, imem_resp=1 → all enables 0 and pc_en=0; next cycle dmem_resp=1 → all enables 1.
5. PRED_MODE=1: op_br, br_en=0, pred_taken_ex=1, pc_plus4_ex=0x44 → redirect_pc=0x44, mispredict=1; br_en=1 with pred_taken_ex=1 → no mispredict.
6. CNT_WIDTH=4: force 20 stall cycles → stall_cnt holds 0xF; assert rst low mid-REDIR_WAIT → redirect_valid=0 and counters=0 asynchronously.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/redirect controller for a 5-stage RV32I pipeline,
// with pending-redirect holding, load-use bubbles and saturating perf counters.
`default_nettype none

module pipeline_hazard_ctrl #(
   parameter int XLEN            = 32,
   parameter int CNT_WIDTH       = 32,
   parameter int LU_STALL_CYCLES = 1,
   parameter int PRED_MODE       = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 imem_resp,
   input  logic                 dmem_resp,
   input  logic                 dmem_read_mem,
   input  logic                 dmem_write_mem,
   input  logic [4:0]           rs1_id,
   input  logic [4:0]           rs2_id,
   input  logic                 rs1_used_id,
   input  logic                 rs2_used_id,
   input  logic [6:0]           opcode_ex,
   input  logic [4:0]           rd_ex,
   input  logic                 br_en,
   input  logic                 pred_taken_ex,
   input  logic [XLEN-1:0]      alu_out_ex,
   input  logic [XLEN-1:0]      pc_plus4_ex,
   input  logic                 perf_clr,
   output logic                 pc_en,
   output logic                 redirect_valid,
   output logic [XLEN-1:0]      redirect_pc,
   output logic                 IFID_en,
   output logic                 IDEX_en,
   output logic                 EXMEM_en,
   output logic                 MEMWB_en,
   output logic                 IFID_flush,
   output logic                 IDEX_flush,
   output logic                 mispredict,
   output logic [CNT_WIDTH-1:0] mispredict_cnt,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] lu_bubble_cnt
);

   localparam logic [6:0] c_OP_LOAD = 7'b0000011;
   localparam logic [6:0] c_OP_BR   = 7'b1100011;
   localparam logic [6:0] c_OP_JAL  = 7'b1101111;
   localparam logic [6:0] c_OP_JALR = 7'b1100111;
   localparam logic [1:0] c_LU_RELOAD = 2'(LU_STALL_CYCLES - 1);

   typedef enum logic [1:0] {
      S_RUN        = 2'd0,
      S_LU_STALL   = 2'd1,
      S_REDIR_WAIT = 2'd2
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [1:0]      r_lu_cnt, w_lu_cnt_nxt;
   logic [XLEN-1:0] r_redir_pc;

   logic w_op_br, w_op_jal, w_op_jalr, w_op_load;
   logic w_dreq, w_mem_ok, w_full_adv, w_back_adv;
   logic w_mispred_raw, w_load_use, w_redir_ld, w_lu_bubble;
   logic [XLEN-1:0] w_target;

   assign w_op_br   = (opcode_ex == c_OP_BR);
   assign w_op_jal  = (opcode_ex == c_OP_JAL);
   assign w_op_jalr = (opcode_ex == c_OP_JALR);
   assign w_op_load = (opcode_ex == c_OP_LOAD);

   assign w_dreq     = dmem_read_mem | dmem_write_mem;
   assign w_mem_ok   = dmem_resp | ~w_dreq;
   assign w_full_adv = imem_resp & w_mem_ok;
   assign w_back_adv = w_full_adv | (~imem_resp & dmem_resp);

   always_comb begin
      if (PRED_MODE == 0)
         w_mispred_raw = (w_op_br & br_en) | w_op_jal | w_op_jalr;
      else
         w_mispred_raw = (w_op_br & (br_en != pred_taken_ex)) | w_op_jalr
                       | (w_op_jal & ~pred_taken_ex);
   end

   always_comb begin
      if (w_op_jalr)
         w_target = {alu_out_ex[XLEN-1:1], 1'b0};
      else if (w_op_jal || (w_op_br && br_en))
         w_target = alu_out_ex;
      else
         w_target = pc_plus4_ex;
   end

   // x0 never creates a dependency, and unused operand fields are don't-care.
   assign w_load_use = w_op_load && (rd_ex != 5'd0) &&
                       ((rs1_used_id && (rd_ex == rs1_id)) ||
                        (rs2_used_id && (rd_ex == rs2_id)));

   assign mispredict = w_mispred_raw & (r_state == S_RUN);

   always_comb begin
      pc_en          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      IFID_en        = w_back_adv;
      IDEX_en        = w_back_adv;
      EXMEM_en       = w_back_adv;
      MEMWB_en       = w_back_adv;
      IFID_flush     = ~imem_resp & w_back_adv;
      IDEX_flush     = 1'b0;
      w_state_nxt    = r_state;
      w_lu_cnt_nxt   = r_lu_cnt;
      w_redir_ld     = 1'b0;
      w_lu_bubble    = 1'b0;
      case (r_state)
         S_RUN: begin
            if (w_mispred_raw && w_full_adv) begin
               redirect_valid = 1'b1;
               redirect_pc    = w_target;
               pc_en          = 1'b1;
               IFID_flush     = 1'b1;
               IDEX_flush     = 1'b1;
            end else if (w_mispred_raw && w_back_adv && !imem_resp) begin
               // Fetch is busy on the wrong path; hold the target until I-mem answers.
               w_redir_ld  = 1'b1;
               IFID_flush  = 1'b1;
               IDEX_flush  = 1'b1;
               w_state_nxt = S_REDIR_WAIT;
            end else if (!w_mispred_raw && w_load_use && w_back_adv) begin
               IFID_en     = 1'b0;
               IDEX_flush  = 1'b1;
               w_lu_bubble = 1'b1;
               if (LU_STALL_CYCLES > 1) begin
                  w_lu_cnt_nxt = c_LU_RELOAD;
                  w_state_nxt  = S_LU_STALL;
               end
            end else begin
               pc_en = w_full_adv;
            end
         end
         S_LU_STALL: begin
            if (w_back_adv) begin
               IFID_en      = 1'b0;
               IDEX_flush   = 1'b1;
               w_lu_bubble  = 1'b1;
               w_lu_cnt_nxt = r_lu_cnt - 2'd1;
               if (r_lu_cnt == 2'd1)
                  w_state_nxt = S_RUN;
            end
         end
         S_REDIR_WAIT: begin
            redirect_valid = 1'b1;
            redirect_pc    = r_redir_pc;
            IFID_flush     = w_back_adv;
            if (imem_resp) begin
               pc_en       = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_RUN;
         r_lu_cnt       <= 2'd0;
         r_redir_pc     <= '0;
         mispredict_cnt <= '0;
         stall_cnt      <= '0;
         lu_bubble_cnt  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_lu_cnt <= w_lu_cnt_nxt;
         if (w_redir_ld)
            r_redir_pc <= w_target;
         if (perf_clr) begin
            mispredict_cnt <= '0;
            stall_cnt      <= '0;
            lu_bubble_cnt  <= '0;
         end else begin
            if (mispredict && w_back_adv && (mispredict_cnt != '1))
               mispredict_cnt <= mispredict_cnt + 1'b1;
            if (!pc_en && (stall_cnt != '1))
               stall_cnt <= stall_cnt + 1'b1;
            if (w_lu_bubble && (lu_bubble_cnt != '1))
               lu_bubble_cnt <= lu_bubble_cnt + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl: two instances
// (static predictor / 3-cycle load-use / 4-bit counters, and external predictor / 1-cycle).
`default_nettype none

module tb_pipeline_hazard_ctrl;

   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   logic        clk, rst;
   logic        imem_resp, dmem_resp, dmem_read_mem, dmem_write_mem;
   logic [4:0]  rs1_id, rs2_id, rd_ex;
   logic        rs1_used_id, rs2_used_id, br_en, pred_taken_ex, perf_clr;
   logic [6:0]  opcode_ex;
   logic [31:0] alu_out_ex, pc_plus4_ex;

   logic        pc_en_0, rv_0, ifid_en_0, idex_en_0, exmem_en_0, memwb_en_0;
   logic        ifid_fl_0, idex_fl_0, mp_0;
   logic [31:0] rp_0;
   logic [3:0]  mpc_0, stc_0, luc_0;

   logic        pc_en_1, rv_1, ifid_en_1, idex_en_1, exmem_en_1, memwb_en_1;
   logic        ifid_fl_1, idex_fl_1, mp_1;
   logic [31:0] rp_1;
   logic [31:0] mpc_1, stc_1, luc_1;

   int n_checks = 0;
   int n_errors = 0;

   pipeline_hazard_ctrl #(.XLEN(32), .CNT_WIDTH(4), .LU_STALL_CYCLES(3), .PRED_MODE(0)) u_dut0 (
      .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
      .dmem_read_mem(dmem_read_mem), .dmem_write_mem(dmem_write_mem),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
      .opcode_ex(opcode_ex), .rd_ex(rd_ex), .br_en(br_en), .pred_taken_ex(pred_taken_ex),
      .alu_out_ex(alu_out_ex), .pc_plus4_ex(pc_plus4_ex), .perf_clr(perf_clr),
      .pc_en(pc_en_0), .redirect_valid(rv_0), .redirect_pc(rp_0),
      .IFID_en(ifid_en_0), .IDEX_en(idex_en_0), .EXMEM_en(exmem_en_0), .MEMWB_en(memwb_en_0),
      .IFID_flush(ifid_fl_0), .IDEX_flush(idex_fl_0), .mispredict(mp_0),
      .mispredict_cnt(mpc_0), .stall_cnt(stc_0), .lu_bubble_cnt(luc_0));

   pipeline_hazard_ctrl #(.XLEN(32), .CNT_WIDTH(32), .LU_STALL_CYCLES(1), .PRED_MODE(1)) u_dut1 (
      .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
      .dmem_read_mem(dmem_read_mem), .dmem_write_mem(dmem_write_mem),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
      .opcode_ex(opcode_ex), .rd_ex(rd_ex), .br_en(br_en), .pred_taken_ex(pred_taken_ex),
      .alu_out_ex(alu_out_ex), .pc_plus4_ex(pc_plus4_ex), .perf_clr(perf_clr),
      .pc_en(pc_en_1), .redirect_valid(rv_1), .redirect_pc(rp_1),
      .IFID_en(ifid_en_1), .IDEX_en(idex_en_1), .EXMEM_en(exmem_en_1), .MEMWB_en(memwb_en_1),
      .IFID_flush(ifid_fl_1), .IDEX_flush(idex_fl_1), .mispredict(mp_1),
      .mispredict_cnt(mpc_1), .stall_cnt(stc_1), .lu_bubble_cnt(luc_1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      imem_resp = 1'b1; dmem_resp = 1'b0; dmem_read_mem = 1'b0; dmem_write_mem = 1'b0;
      rs1_id = 5'd0; rs2_id = 5'd0; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
      opcode_ex = 7'd0; rd_ex = 5'd0; br_en = 1'b0; pred_taken_ex = 1'b0;
      alu_out_ex = 32'd0; pc_plus4_ex = 32'd0; perf_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      set_idle();
      imem_resp = 1'b0;
      @(posedge clk);
      #1;
      check("rst_outs0", {28'd0, pc_en_0, rv_0, ifid_en_0, idex_fl_0}, 32'd0);
      check("rst_misc0", {28'd0, ifid_fl_0, mp_0, exmem_en_0, memwb_en_0}, 32'd0);
      check("rst_rpc0", rp_0, 32'd0);
      check("rst_cnts0", {20'd0, mpc_0, stc_0, luc_0}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Taken branch resolved with fetch available: same-cycle redirect
      set_idle(); perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0; opcode_ex = OP_BR; br_en = 1'b1; alu_out_ex = 32'h100;
      #1;
      check("br_rv", rv_0, 1'b1);
      check("br_rpc", rp_0, 32'h100);
      check("br_pcen", pc_en_0, 1'b1);
      check("br_flush", {ifid_fl_0, idex_fl_0}, 2'b11);
      check("br_mp", mp_0, 1'b1);
      tick();
      check("br_mpcnt", mpc_0, 4'd1);

      // jalr while I-mem busy: pending redirect
      opcode_ex = OP_JALR; br_en = 1'b0; alu_out_ex = 32'h203; imem_resp = 1'b0; dmem_resp = 1'b1;
      #1;
      check("jalr_c0", {pc_en_0, rv_0, ifid_fl_0, idex_fl_0, mp_0}, 5'b00111);
      tick();
      opcode_ex = 7'd0;
      #1;
      check("rw1", {pc_en_0, rv_0, ifid_fl_0, mp_0}, 4'b0110);
      check("rw1_rpc", rp_0, 32'h202);
      tick();
      #1;
      check("rw2", {pc_en_0, rv_0}, 2'b01);
      check("rw2_rpc", rp_0, 32'h202);
      tick();
      imem_resp = 1'b1;
      #1;
      check("rw3", {pc_en_0, rv_0}, 2'b11);
      check("rw3_rpc", rp_0, 32'h202);
      tick();
      dmem_resp = 1'b0;
      #1;
      check("rw_done", {pc_en_0, rv_0}, 2'b10);
      check("rw_mpcnt", mpc_0, 4'd2);

      // Load-use: 3 bubbles on dut0, 1 bubble on dut1
      set_idle(); perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0; opcode_ex = OP_LOAD; rd_ex = 5'd5; rs2_id = 5'd5; rs2_used_id = 1'b1;
      #1;
      check("lu_b1", {ifid_en_0, idex_fl_0, pc_en_0}, 3'b010);
      check("lu_b1_d1", {ifid_en_1, idex_fl_1, pc_en_1}, 3'b010);
      tick();
      opcode_ex = 7'd0;
      #1;
      check("lu_b2", {ifid_en_0, idex_fl_0, pc_en_0}, 3'b010);
      check("lu_run_d1", {ifid_en_1, idex_fl_1, pc_en_1}, 3'b101);
      tick();
      #1;
      check("lu_b3", {ifid_en_0, idex_fl_0, pc_en_0}, 3'b010);
      tick();
      #1;
      check("lu_end", {ifid_en_0, idex_fl_0, pc_en_0}, 3'b101);
      check("lu_cnt0", luc_0, 4'd3);
      check("lu_cnt1", luc_1, 32'd1);
      opcode_ex = OP_LOAD; rd_ex = 5'd0; rs1_id = 5'd0; rs1_used_id = 1'b1; rs2_used_id = 1'b0;
      #1;
      check("lu_x0", {ifid_en_0, idex_fl_0, pc_en_0}, 3'b101);
      rd_ex = 5'd5; rs1_used_id = 1'b0; rs2_id = 5'd5; rs2_used_id = 1'b0;
      #1;
      check("lu_unused", {ifid_en_0, idex_fl_0, pc_en_0}, 3'b101);
      rs1_id = 5'd5; rs1_used_id = 1'b1;
      #1;
      check("lu_rs1", {ifid_en_0, idex_fl_0, pc_en_0}, 3'b010);
      tick();
      opcode_ex = 7'd0;
      tick();
      tick();

      // D-mem stall freezes everything, then releases
      set_idle(); dmem_read_mem = 1'b1;
      #1;
      check("dm_stall", {ifid_en_0, idex_en_0, exmem_en_0, memwb_en_0, pc_en_0}, 5'b00000);
      tick();
      dmem_resp = 1'b1;
      #1;
      check("dm_go", {ifid_en_0, idex_en_0, exmem_en_0, memwb_en_0, pc_en_0}, 5'b11111);
      tick();

      // External predictor mode
      set_idle(); opcode_ex = OP_BR; br_en = 1'b0; pred_taken_ex = 1'b1; pc_plus4_ex = 32'h44;
      #1;
      check("p1_mp", {mp_1, rv_1}, 2'b11);
      check("p1_rpc", rp_1, 32'h44);
      check("p0_nt", {mp_0, rv_0}, 2'b00);
      tick();
      br_en = 1'b1;
      #1;
      check("p1_ok", {mp_1, rv_1}, 2'b00);
      opcode_ex = OP_JAL; alu_out_ex = 32'h80;
      #1;
      check("p1_jal", mp_1, 1'b0);
      check("p0_jal", {mp_0, rv_0}, 2'b11);
      check("p0_jal_rpc", rp_0, 32'h80);
      tick();

      // Counter saturation, clear priority, reset during pending redirect
      set_idle(); imem_resp = 1'b0; perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      check("st_sat", stc_0, 4'hF);
      check("st_20", stc_1, 32'd20);
      perf_clr = 1'b1;
      tick();
      check("st_clr", stc_0, 4'd0);
      perf_clr = 1'b0; opcode_ex = OP_JALR; alu_out_ex = 32'h300; dmem_resp = 1'b1;
      tick();
      opcode_ex = 7'd0;
      #1;
      check("rw_pre", {rv_0, mpc_0 != 4'd0}, 2'b11);
      check("rw_pre_rpc", rp_0, 32'h300);
      #1;
      rst = 1'b0;
      #1;
      check("arst_rv", rv_0, 1'b0);
      check("arst_cnt", {20'd0, mpc_0, stc_0, luc_0}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check("post_rst", {rv_0, pc_en_0, ifid_fl_0}, 3'b001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
